// File: rtl/sram_pkg.sv
// Shared types and helpers for the single-port byte-enable SRAM.
// Helpers work on a max-width word; callers size-cast in and out.
package sram_pkg;

  localparam int SRAM_MAX_DW = 1024;
  localparam int SRAM_MAX_NB = SRAM_MAX_DW / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } init_state_e;

  // ben is active-low: a 0 bit takes the new byte
  function automatic logic [SRAM_MAX_DW-1:0] merge_be(
    input logic [SRAM_MAX_DW-1:0] old_w,
    input logic [SRAM_MAX_DW-1:0] new_w,
    input logic [SRAM_MAX_NB-1:0] ben
  );
    merge_be = old_w;
    for (int b = 0; b < SRAM_MAX_NB; b++)
      if (!ben[b]) merge_be[b*8 +: 8] = new_w[b*8 +: 8];
  endfunction

  // Even parity per byte: the stored bit makes the 9-bit group have an even count
  function automatic logic [SRAM_MAX_NB-1:0] byte_parity(input logic [SRAM_MAX_DW-1:0] w);
    byte_parity = '0;
    for (int b = 0; b < SRAM_MAX_NB; b++)
      byte_parity[b] = ^w[b*8 +: 8];
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Post-reset zero-fill sequencer: walks addresses 0..DEPTH-1 once, then idles
// until the next reset.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH  = 8192,
  parameter int AWIDTH = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy_o,
  output logic [AWIDTH-1:0] init_addr_o,
  output logic              init_we_o
);

  init_state_e       state, state_nxt;
  logic [AWIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + AWIDTH'(1);
        if (cnt == AWIDTH'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy_o      = (state == ST_INIT);
  assign init_we_o   = busy_o;
  assign init_addr_o = cnt;

endmodule

// File: rtl/sram_sp_bwe.sv
// Single-port synchronous SRAM, active-low byte write enables, registered
// write-first output. Define SRAM_PARITY_EN for per-byte even parity + parity_err_o.
module sram_sp_bwe
  import sram_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 8192,
  parameter int AWIDTH    = 13,
  parameter int INIT_ZERO = 1,
  localparam int NBYTES   = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen_i,
  input  logic              wen_i,
  input  logic [NBYTES-1:0] ben_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              init_busy_o
`ifdef SRAM_PARITY_EN
  ,
  output logic              parity_err_o
`endif
);

  logic              busy, init_we;
  logic [AWIDTH-1:0] init_addr;

  generate
    if (INIT_ZERO != 0) begin : g_init
      sram_init_ctrl #(.DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_init (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy_o     (busy),
        .init_addr_o(init_addr),
        .init_we_o  (init_we)
      );
    end else begin : g_no_init
      assign busy      = 1'b0;
      assign init_we   = 1'b0;
      assign init_addr = '0;
    end
  endgenerate

  assign init_busy_o = busy;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              in_range, acc, ext_we, ext_rd;
  logic [DWIDTH-1:0] rd_word, wr_merged, wr_word;
  logic [AWIDTH-1:0] wr_addr;
  logic              we;

  assign in_range  = (32'(addr_i) < 32'(DEPTH));
  assign acc       = !cen_i && !busy && in_range;
  assign ext_we    = acc && !wen_i;
  assign ext_rd    = acc && wen_i;
  assign rd_word   = mem[addr_i];
  assign wr_merged = DWIDTH'(merge_be(SRAM_MAX_DW'(rd_word), SRAM_MAX_DW'(data_i),
                                      SRAM_MAX_NB'(ben_i)));

  // Zero-fill owns the write port while busy; external requests are gated off by acc
  assign we      = init_we || ext_we;
  assign wr_addr = init_we ? init_addr : addr_i;
  assign wr_word = init_we ? '0 : wr_merged;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       data_o <= '0;
    else if (ext_we)                  data_o <= wr_merged;
    else if (ext_rd)                  data_o <= rd_word;
    else if (!cen_i && !busy && wen_i) data_o <= '0;  // out-of-range read
  end

`ifdef SRAM_PARITY_EN
  logic [NBYTES-1:0] pmem [DEPTH];
  logic [NBYTES-1:0] rd_par, new_par, wr_par, chk_par;

  assign rd_par  = pmem[addr_i];
  assign new_par = NBYTES'(byte_parity(SRAM_MAX_DW'(data_i)));
  assign chk_par = NBYTES'(byte_parity(SRAM_MAX_DW'(rd_word)));

  // Untouched bytes keep their stored parity so latent corruption stays visible
  always_comb begin
    wr_par = rd_par;
    for (int b = 0; b < NBYTES; b++)
      if (!ben_i[b]) wr_par[b] = new_par[b];
    if (init_we) wr_par = '0;
  end

  always_ff @(posedge clk) begin
    if (we) pmem[wr_addr] <= wr_par;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_o <= 1'b0;
    else        parity_err_o <= ext_rd && (chk_par != rd_par);
  end
`endif

endmodule

// File: tb/tb_sram_sp_bwe.sv
// Directed bench: two instances (DEPTH=8 and DEPTH=6) share one stimulus stream.
module tb_sram_sp_bwe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1, wen = 1'b1;
  logic [3:0]  ben = 4'hF;
  logic [2:0]  addr = '0;
  logic [31:0] data = '0;
  logic [31:0] d8, d6;
  logic        busy8, busy6;
`ifdef SRAM_PARITY_EN
  logic        perr8, perr6;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_mem [8];

  always #5 clk = ~clk;

  sram_sp_bwe #(.DWIDTH(32), .DEPTH(8), .AWIDTH(3), .INIT_ZERO(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .cen_i(cen), .wen_i(wen), .ben_i(ben),
    .addr_i(addr), .data_i(data), .data_o(d8), .init_busy_o(busy8)
`ifdef SRAM_PARITY_EN
    , .parity_err_o(perr8)
`endif
  );

  sram_sp_bwe #(.DWIDTH(32), .DEPTH(6), .AWIDTH(3), .INIT_ZERO(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .cen_i(cen), .wen_i(wen), .ben_i(ben),
    .addr_i(addr), .data_i(data), .data_o(d6), .init_busy_o(busy6)
`ifdef SRAM_PARITY_EN
    , .parity_err_o(perr6)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic c, input logic w, input logic [3:0] b,
                    input logic [2:0] a, input logic [31:0] d);
    cen = c; wen = w; ben = b; addr = a; data = d;
    cyc();
  endtask

  task automatic idle();
    cen = 1'b1; wen = 1'b1; ben = 4'hF;
  endtask

  // Counts edges after release until busy drops on each instance
  task automatic wait_init(output int n8, output int n6, input bit poke);
    n8 = 0; n6 = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (poke && i == 1) begin
        cen = 1'b0; wen = 1'b0; ben = 4'h0; addr = 3'd0; data = 32'hDEADBEEF;
      end
      if (n8 == 0 && !busy8) n8 = i;
      if (n6 == 0 && !busy6) n6 = i;
      if (n8 != 0 && n6 != 0) break;
    end
    idle();
  endtask

  task automatic test_reset();
    int n8, n6;
    rst_n = 1'b0; idle();
    cyc(); cyc();
    vectors++;
    if (d8 !== 32'h0 || busy8 !== 1'b1 || d6 !== 32'h0 || busy6 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: d8=%h busy8=%b d6=%h busy6=%b, want 0/1/0/1", d8, busy8, d6, busy6);
    end
    rst_n = 1'b1;
    wait_init(n8, n6, 1'b0);
    vectors++;
    if (n8 != 8) begin errors++; $display("FAIL init_len8: got %0d cycles, want 8", n8); end
    vectors++;
    if (n6 != 6) begin errors++; $display("FAIL init_len6: got %0d cycles, want 6", n6); end
    for (int a = 0; a < 8; a++) begin
      op(1'b0, 1'b1, 4'hF, 3'(a), 32'h0);
      vectors++;
      if (d8 !== 32'h0) begin errors++; $display("FAIL init_read a=%0d: got %h want 0", a, d8); end
    end
    idle();
    for (int a = 0; a < 8; a++) exp_mem[a] = 32'h0;
  endtask

  task automatic test_byte_enable();
    op(1'b0, 1'b0, 4'b0000, 3'd3, 32'hA5A5A5A5);
    vectors++;
    if (d8 !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_full: got %h want a5a5a5a5", d8); end
    op(1'b0, 1'b0, 4'b1010, 3'd3, 32'h11223344);
    vectors++;
    if (d8 !== 32'hA522A544) begin errors++; $display("FAIL wr_merge: got %h want a522a544", d8); end
    op(1'b0, 1'b1, 4'b0000, 3'd3, 32'hFFFFFFFF);
    vectors++;
    if (d8 !== 32'hA522A544 || d6 !== 32'hA522A544) begin
      errors++; $display("FAIL rd_merge: d8=%h d6=%h want a522a544", d8, d6);
    end
    exp_mem[3] = 32'hA522A544;
    idle();
  endtask

  task automatic test_standby();
    op(1'b0, 1'b0, 4'b0000, 3'd5, 32'h00000005);
    op(1'b0, 1'b1, 4'hF, 3'd0, 32'h0);     // move data_o away first
    op(1'b0, 1'b1, 4'hF, 3'd5, 32'h0);
    vectors++;
    if (d8 !== 32'h5) begin errors++; $display("FAIL rd_5: got %h want 00000005", d8); end
    exp_mem[5] = 32'h5;
    for (int i = 0; i < 10; i++) begin
      op(1'b1, i[0], 4'(i), 3'(i), 32'hC0DE0000 + 32'(i));
      vectors++;
      if (d8 !== 32'h5 || d6 !== 32'h5) begin
        errors++; $display("FAIL standby_hold i=%0d: d8=%h d6=%h want 00000005", i, d8, d6);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    op(1'b0, 1'b0, 4'h0, 3'd1, 32'h01010101);
    op(1'b0, 1'b0, 4'h0, 3'd2, 32'h02020202);
    op(1'b0, 1'b1, 4'hF, 3'd1, 32'h0);
    vectors++;
    if (d8 !== 32'h01010101) begin errors++; $display("FAIL b2b_rd1: got %h want 01010101", d8); end
    op(1'b0, 1'b0, 4'b0111, 3'd2, 32'hEE000000);
    vectors++;
    if (d8 !== 32'hEE020202) begin errors++; $display("FAIL b2b_wr2: got %h want ee020202", d8); end
    op(1'b0, 1'b1, 4'hF, 3'd2, 32'h0);
    vectors++;
    if (d8 !== 32'hEE020202) begin errors++; $display("FAIL b2b_raw: got %h want ee020202", d8); end
    exp_mem[1] = 32'h01010101;
    exp_mem[2] = 32'hEE020202;
    idle();
  endtask

  task automatic test_out_of_range();
    op(1'b0, 1'b0, 4'h0, 3'd7, 32'hFFFFFFFF);
    op(1'b0, 1'b1, 4'hF, 3'd7, 32'h0);
    vectors++;
    if (d6 !== 32'h0) begin errors++; $display("FAIL oor_read6: got %h want 0", d6); end
    vectors++;
    if (d8 !== 32'hFFFFFFFF) begin errors++; $display("FAIL top_addr8: got %h want ffffffff", d8); end
    exp_mem[7] = 32'hFFFFFFFF;
    for (int a = 0; a < 6; a++) begin
      op(1'b0, 1'b1, 4'hF, 3'(a), 32'h0);
      vectors++;
      if (d6 !== exp_mem[a]) begin
        errors++; $display("FAIL oor_intact a=%0d: got %h want %h", a, d6, exp_mem[a]);
      end
    end
    idle();
  endtask

  task automatic test_restart();
    int n8, n6;
    bit leaked;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    cyc(); cyc(); cyc();
    rst_n = 1'b0; #2;
    vectors++;
    if (busy8 !== 1'b1 || d8 !== 32'h0) begin
      errors++; $display("FAIL midinit_reset: busy=%b d8=%h want 1/0", busy8, d8);
    end
    cyc(); rst_n = 1'b1;
    leaked = 1'b0;
    n8 = 0; n6 = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 1) begin
        cen = 1'b0; wen = 1'b0; ben = 4'h0; addr = 3'd0; data = 32'hDEADBEEF;
      end
      if (busy8 && d8 !== 32'h0) leaked = 1'b1;
      if (n8 == 0 && !busy8) n8 = i;
      if (n6 == 0 && !busy6) n6 = i;
      if (n8 != 0 && n6 != 0) break;
    end
    idle();
    vectors++;
    if (n8 != 8) begin errors++; $display("FAIL restart_len8: got %0d want 8", n8); end
    vectors++;
    if (leaked) begin errors++; $display("FAIL busy_output: data_o nonzero while busy, want 0"); end
    for (int a = 0; a < 8; a++) begin
      op(1'b0, 1'b1, 4'hF, 3'(a), 32'h0);
      vectors++;
      if (d8 !== 32'h0) begin errors++; $display("FAIL refill a=%0d: got %h want 0", a, d8); end
      exp_mem[a] = 32'h0;
    end
    idle();
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity();
    op(1'b0, 1'b0, 4'h0, 3'd2, 32'h12345678);
    op(1'b0, 1'b1, 4'hF, 3'd2, 32'h0);
    vectors++;
    if (perr8 !== 1'b0) begin errors++; $display("FAIL par_clean: got %b want 0", perr8); end
    idle();
    dut8.mem[2] = dut8.mem[2] ^ 32'h00000100;
    cyc();
    op(1'b0, 1'b1, 4'hF, 3'd2, 32'h0);
    vectors++;
    if (perr8 !== 1'b1) begin errors++; $display("FAIL par_err: got %b want 1", perr8); end
    op(1'b0, 1'b1, 4'hF, 3'd1, 32'h0);
    vectors++;
    if (perr8 !== 1'b0) begin errors++; $display("FAIL par_pulse: got %b want 0", perr8); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_byte_enable();
    test_standby();
    test_back_to_back();
    test_out_of_range();
    test_restart();
`ifdef SRAM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
